// File: rtl/alu_axil_slave.sv
// AXI4-Lite register front-end and operation sequencer for the ALU (A, B, CTRL, RESULT).
// Define ALU_MUL_EN to build the iterative shift-add multiplier for opcode 7.
module alu_axil_slave #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            done_irq
);

  localparam int unsigned DW       = C_S_AXI_DATA_WIDTH;
  localparam int unsigned SW       = DW / 8;
  localparam int unsigned ADDR_LSB = 2;
  localparam int unsigned START_B  = 8;
  localparam int unsigned BUSY_B   = 16;
  localparam int unsigned DONE_B   = 17;
  localparam int unsigned ZERO_B   = 18;
  localparam int unsigned CARRY_B  = 19;
  localparam int unsigned ERR_B    = 20;

  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] REG_A     = 2'd0;
  localparam logic [1:0] REG_B     = 2'd1;
  localparam logic [1:0] REG_CTRL  = 2'd2;
  localparam logic [1:0] REG_RES   = 2'd3;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRL = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL} state_t;

  state_t state_q, state_d;

  logic          aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic          awready_q, awready_d, wready_q, wready_d;
  logic          bvalid_q, bvalid_d, arready_q, arready_d, rvalid_q, rvalid_d;
  logic [1:0]    awsel_q;
  logic [DW-1:0] wdata_q;
  logic [SW-1:0] wstrb_q;
  logic [DW-1:0] rdata_q, rdata_d, ctrl_rd;

  logic [DW-1:0] a_q, b_q, result_q, opa_q, opb_q;
  logic [2:0]    opcode_q, opc_q, op_new;
  logic          busy_q, done_q, zero_q, carry_q, err_q, done_irq_q;

  logic          aw_hs, w_hs, ar_hs, commit;
  logic          wr_a, wr_b, op_wr, start;
  logic          fin;
  logic [DW-1:0] alu_res;
  logic [DW:0]   alu_sum;
  logic          alu_carry, alu_err;

`ifdef ALU_MUL_EN
  localparam int unsigned CW = 6;
  logic [2*DW-1:0] acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW:0]     mul_sum;
  logic [DW-1:0]   mul_add;
`endif

  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

  function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_v,
                                                input logic [DW-1:0] new_v,
                                                input logic [SW-1:0] strb);
    logic [DW-1:0] r;
    r = old_v;
    for (int i = 0; i < int'(SW); i++) begin
      if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  assign aw_hs  = S_AXI_AWVALID & awready_q;
  assign w_hs   = S_AXI_WVALID & wready_q;
  assign ar_hs  = S_AXI_ARVALID & arready_q;
  // Commit happens on the first cycle both address and data are held.
  assign commit = aw_held_q & w_held_q;
  assign wr_a   = commit && (awsel_q == REG_A);
  assign wr_b   = commit && (awsel_q == REG_B);
  assign op_wr  = commit && (awsel_q == REG_CTRL) && wstrb_q[0];
  assign start  = commit && (awsel_q == REG_CTRL) && wstrb_q[1] && wdata_q[START_B]
                  && (state_q == S_IDLE);
  assign op_new = op_wr ? wdata_q[2:0] : opcode_q;

  always_comb begin
    aw_held_d = (aw_held_q | aw_hs) & ~commit;
    w_held_d  = (w_held_q | w_hs) & ~commit;
    bvalid_d  = commit | (bvalid_q & ~S_AXI_BREADY);
    awready_d = ~aw_held_d & ~bvalid_d;
    wready_d  = ~w_held_d & ~bvalid_d;
    rvalid_d  = ar_hs | (rvalid_q & ~S_AXI_RREADY);
    arready_d = ~rvalid_d;
  end

  always_comb begin
    ctrl_rd          = '0;
    ctrl_rd[2:0]     = opcode_q;
    ctrl_rd[BUSY_B]  = busy_q;
    ctrl_rd[DONE_B]  = done_q;
    ctrl_rd[ZERO_B]  = zero_q;
    ctrl_rd[CARRY_B] = carry_q;
    ctrl_rd[ERR_B]   = err_q;
    case (S_AXI_ARADDR[ADDR_LSB +: 2])
      REG_A:    rdata_d = a_q;
      REG_B:    rdata_d = b_q;
      REG_CTRL: rdata_d = ctrl_rd;
      default:  rdata_d = result_q;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) state_q <= S_IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef ALU_MUL_EN
          state_d = (op_new == 3'd7) ? S_MUL : S_EXEC;
`else
          state_d = S_EXEC;
`endif
        end
      end
      S_EXEC: state_d = S_IDLE;
`ifdef ALU_MUL_EN
      S_MUL:  if (cnt_q == CW'(DW-1)) state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and completion strobe for the current sequencer state.
  always_comb begin
    fin       = 1'b0;
    alu_res   = '0;
    alu_sum   = '0;
    alu_carry = 1'b0;
    alu_err   = 1'b0;
`ifdef ALU_MUL_EN
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    mul_sum = '0;
    mul_add = '0;
    if (start) begin
      acc_d = (2*DW)'(b_q);
      cnt_d = '0;
    end
`endif
    case (state_q)
      S_EXEC: begin
        fin = 1'b1;
        case (opc_q)
          OP_ADD: begin
            alu_sum   = {1'b0, opa_q} + {1'b0, opb_q};
            alu_res   = alu_sum[DW-1:0];
            alu_carry = alu_sum[DW];
          end
          OP_SUB: begin
            alu_sum   = {1'b0, opa_q} - {1'b0, opb_q};
            alu_res   = alu_sum[DW-1:0];
            alu_carry = alu_sum[DW];
          end
          OP_AND:  alu_res = opa_q & opb_q;
          OP_OR:   alu_res = opa_q | opb_q;
          OP_XOR:  alu_res = opa_q ^ opb_q;
          OP_SLL:  alu_res = opa_q << opb_q[4:0];
          OP_SRL:  alu_res = opa_q >> opb_q[4:0];
          default: alu_err = 1'b1;
        endcase
      end
`ifdef ALU_MUL_EN
      S_MUL: begin
        mul_add = acc_q[0] ? opa_q : '0;
        mul_sum = {1'b0, acc_q[2*DW-1:DW]} + {1'b0, mul_add};
        acc_d   = {mul_sum, acc_q[DW-1:1]};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(DW-1)) begin
          fin       = 1'b1;
          alu_res   = acc_d[DW-1:0];
          alu_carry = |acc_d[2*DW-1:DW];
        end
      end
`endif
      default: ;
    endcase
  end

`ifdef ALU_MUL_EN
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end
`endif

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      aw_held_q <= 1'b0;  w_held_q  <= 1'b0;
      awready_q <= 1'b0;  wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;  arready_q <= 1'b0;
      rvalid_q  <= 1'b0;  rdata_q   <= '0;
      awsel_q   <= '0;    wdata_q   <= '0;    wstrb_q <= '0;
      a_q       <= '0;    b_q       <= '0;    result_q <= '0;
      opa_q     <= '0;    opb_q     <= '0;
      opcode_q  <= '0;    opc_q     <= '0;
      busy_q    <= 1'b0;  done_q    <= 1'b0;
      zero_q    <= 1'b0;  carry_q   <= 1'b0;  err_q <= 1'b0;
      done_irq_q <= 1'b0;
    end else begin
      aw_held_q <= aw_held_d;  w_held_q  <= w_held_d;
      awready_q <= awready_d;  wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;   arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      if (ar_hs) rdata_q <= rdata_d;
      if (aw_hs) awsel_q <= S_AXI_AWADDR[ADDR_LSB +: 2];
      if (w_hs) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
      if (wr_a)  a_q      <= merge_bytes(a_q, wdata_q, wstrb_q);
      if (wr_b)  b_q      <= merge_bytes(b_q, wdata_q, wstrb_q);
      if (op_wr) opcode_q <= wdata_q[2:0];
      if (start) begin
        opa_q  <= a_q;
        opb_q  <= b_q;
        opc_q  <= op_new;
        busy_q <= 1'b1;
        done_q <= 1'b0;
      end
      if (fin) begin
        result_q <= alu_res;
        zero_q   <= (alu_res == '0);
        carry_q  <= alu_carry;
        err_q    <= alu_err;
        busy_q   <= 1'b0;
        done_q   <= 1'b1;
      end
      done_irq_q <= fin;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = RESP_OKAY;
  assign done_irq      = done_irq_q;

endmodule

// File: tb/tb_alu_axil_slave.sv
// Scoreboard bench for alu_axil_slave: stimulus tasks queue expected R, B and done_irq
// events; independent monitors pop and compare them when the DUT presents them.
module tb_alu_axil_slave;

  localparam logic [3:0] A_ADDR    = 4'h0;
  localparam logic [3:0] B_ADDR    = 4'h4;
  localparam logic [3:0] CTRL_ADDR = 4'h8;
  localparam logic [3:0] RES_ADDR  = 4'hC;

  logic        clk = 1'b0;
  logic        areset;
  logic [3:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, done_irq;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int exp_b   = 0;
  logic [31:0] exp_rd_q[$];
  string       exp_rd_tag[$];
  int          exp_irq_q[$];
  logic [31:0] mon_data;
  string       mon_tag;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_axil_slave dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(areset),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .done_irq(done_irq)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic flag_unexpected(input string tag, input logic [31:0] val);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got 0x%0h at cycle %0d, expected no event", tag, val, cyc);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp, done_irq});
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) sync();
  endtask

  // Returns the clock edge index on which the later of AW/W was accepted.
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int w_delay, output int hs_cyc);
    bit aw_done, w_done, aw_fire, w_fire;
    aw_done = 1'b0;
    w_done  = 1'b0;
    hs_cyc  = -1;
    awaddr  = addr;
    awvalid = 1'b1;
    wdata   = data;
    wstrb   = strb;
    wvalid  = (w_delay == 0);
    exp_b++;
    for (int k = 0; k < 100 && !(aw_done && w_done); k++) begin
      @(negedge clk);
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      @(posedge clk);
      #1;
      if (aw_fire) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (w_fire)  begin wvalid  = 1'b0; w_done  = 1'b1; end
      if (aw_done && w_done) hs_cyc = cyc;
      else if (!w_done && !wvalid && (k + 1 >= w_delay)) wvalid = 1'b1;
    end
    if (hs_cyc < 0) begin
      awvalid = 1'b0;
      wvalid  = 1'b0;
      flag_unexpected("write_handshake_timeout", 32'(addr));
    end
  endtask

  task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp, input string tag);
    bit done_f, fire;
    done_f = 1'b0;
    exp_rd_q.push_back(exp);
    exp_rd_tag.push_back(tag);
    araddr  = addr;
    arvalid = 1'b1;
    for (int k = 0; k < 100 && !done_f; k++) begin
      @(negedge clk);
      fire = arvalid && arready;
      @(posedge clk);
      #1;
      if (fire) begin arvalid = 1'b0; done_f = 1'b1; end
    end
    if (!done_f) begin
      arvalid = 1'b0;
      flag_unexpected("read_handshake_timeout", 32'(addr));
    end
  endtask

  always @(negedge clk) begin
    if (rvalid && rready) begin
      if (exp_rd_q.size() == 0) flag_unexpected("unexpected_r", rdata);
      else begin
        mon_data = exp_rd_q.pop_front();
        mon_tag  = exp_rd_tag.pop_front();
        check(mon_tag, 64'(rdata), 64'(mon_data));
        check({mon_tag, "_rresp"}, 64'(rresp), 64'(0));
      end
    end
  end

  always @(negedge clk) begin
    if (bvalid && bready) begin
      if (exp_b == 0) flag_unexpected("unexpected_b", 32'(bresp));
      else begin
        exp_b--;
        check("bresp", 64'(bresp), 64'(0));
      end
    end
  end

  always @(negedge clk) begin
    if (done_irq) begin
      if (exp_irq_q.size() == 0) flag_unexpected("unexpected_irq", 32'(cyc));
      else check("irq_cycle", 64'(cyc), 64'(exp_irq_q.pop_front()));
    end
  end

  initial begin
    int n;
    int m;
    areset = 1'b1;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata  = '0; wstrb  = '0; wvalid  = 1'b0; bready = 1'b1;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", all_outs(), 64'(0));
    areset = 1'b0;
    sync();
    check("ready_after_reset", 64'({awready, wready, arready}), 64'(3'b111));

    // Register readback; a read in the commit cycle sees the old value.
    axi_write(A_ADDR, 32'h1111_1111, 4'hF, 0, n);
    axi_read(A_ADDR, 32'h0000_0000, "rd_a_same_cycle");
    axi_write(B_ADDR, 32'h2222_2222, 4'hF, 0, n);
    idle(2);
    axi_read(A_ADDR, 32'h1111_1111, "rd_a");
    axi_read(B_ADDR, 32'h2222_2222, "rd_b");
    axi_write(RES_ADDR, 32'h0000_0005, 4'hF, 0, n);
    idle(2);
    axi_read(RES_ADDR, 32'h0000_0000, "rd_result_ro");

    // ADD overflow to zero.
    axi_write(A_ADDR, 32'hFFFF_FFFF, 4'hF, 0, n);
    axi_write(B_ADDR, 32'h0000_0001, 4'hF, 0, n);
    idle(2);
    axi_write(CTRL_ADDR, 32'h0000_0100, 4'hF, 0, n);
    exp_irq_q.push_back(n + 2);
    idle(4);
    axi_read(RES_ADDR, 32'h0000_0000, "add_result");
    axi_read(CTRL_ADDR, 32'h000E_0000, "add_ctrl");

    // SUB with borrow, plus a CTRL read landing in the completion cycle.
    axi_write(A_ADDR, 32'h0000_0003, 4'hF, 0, n);
    axi_write(B_ADDR, 32'h0000_0005, 4'hF, 0, n);
    idle(3);
    fork
      begin
        axi_write(CTRL_ADDR, 32'h0000_0101, 4'hF, 0, n);
        exp_irq_q.push_back(n + 2);
      end
      begin
        sync();
        sync();
        axi_read(CTRL_ADDR, 32'h000D_0001, "sub_ctrl_busy");
      end
    join
    idle(3);
    axi_read(RES_ADDR, 32'hFFFF_FFFE, "sub_result");
    axi_read(CTRL_ADDR, 32'h000A_0001, "sub_ctrl");

    // Start bit without WSTRB[1] only updates the opcode.
    axi_write(CTRL_ADDR, 32'h0000_0100, 4'b0001, 0, n);
    idle(3);
    axi_read(CTRL_ADDR, 32'h000A_0000, "nostart_ctrl");

    // AW leads W by three cycles; byte strobes on B.
    axi_write(A_ADDR, 32'hA5A5_A5A5, 4'hF, 3, n);
    idle(3);
    axi_read(A_ADDR, 32'hA5A5_A5A5, "split_write_a");
    axi_write(B_ADDR, 32'hDEAD_BEEF, 4'b0101, 0, n);
    idle(2);
    axi_read(B_ADDR, 32'h00AD_00EF, "strobe_b");

    // SLL uses only B[4:0].
    axi_write(A_ADDR, 32'h8000_0001, 4'hF, 0, n);
    axi_write(B_ADDR, 32'h0000_0021, 4'hF, 0, n);
    idle(2);
    axi_write(CTRL_ADDR, 32'h0000_0105, 4'hF, 0, n);
    exp_irq_q.push_back(n + 2);
    idle(4);
    axi_read(RES_ADDR, 32'h0000_0002, "sll_result");
    axi_read(CTRL_ADDR, 32'h0002_0005, "sll_ctrl");

    // MUL.
    axi_write(A_ADDR, 32'h0001_0000, 4'hF, 0, n);
    axi_write(B_ADDR, 32'h0001_0001, 4'hF, 0, n);
    idle(2);
    axi_write(CTRL_ADDR, 32'h0000_0107, 4'hF, 0, n);
`ifdef ALU_MUL_EN
    exp_irq_q.push_back(n + 33);
    while (cyc < n + 9) sync();
    axi_write(CTRL_ADDR, 32'h0000_0107, 4'hF, 0, m);
    idle(3);
    axi_read(CTRL_ADDR, 32'h0001_0007, "mul_ctrl_busy");
    idle(30);
    axi_read(RES_ADDR, 32'h0001_0000, "mul_result");
    axi_read(CTRL_ADDR, 32'h000A_0007, "mul_ctrl");
`else
    exp_irq_q.push_back(n + 2);
    idle(4);
    axi_read(RES_ADDR, 32'h0000_0000, "mul_off_result");
    axi_read(CTRL_ADDR, 32'h0016_0007, "mul_off_ctrl");
`endif

    // Reset in the middle of a MUL.
    idle(2);
    axi_write(CTRL_ADDR, 32'h0000_0107, 4'hF, 0, n);
`ifndef ALU_MUL_EN
    exp_irq_q.push_back(n + 2);
`endif
    while (cyc < n + 15) sync();
    areset = 1'b1;
    sync();
    check("reset_mid_op_outputs", all_outs(), 64'(0));
    sync();
    areset = 1'b0;
    idle(3);
    axi_read(A_ADDR, 32'h0000_0000, "post_reset_a");
    axi_read(CTRL_ADDR, 32'h0000_0000, "post_reset_ctrl");
    axi_write(A_ADDR, 32'h0000_0002, 4'hF, 0, n);
    axi_write(B_ADDR, 32'h0000_0003, 4'hF, 0, n);
    idle(2);
    axi_write(CTRL_ADDR, 32'h0000_0100, 4'hF, 0, n);
    exp_irq_q.push_back(n + 2);
    idle(4);
    axi_read(RES_ADDR, 32'h0000_0005, "post_reset_add");
    axi_read(CTRL_ADDR, 32'h0002_0000, "post_reset_ctrl_done");

    idle(40);
    check("irq_outstanding", 64'(exp_irq_q.size()), 64'(0));
    check("r_outstanding", 64'(exp_rd_q.size()), 64'(0));
    check("b_outstanding", 64'(exp_b), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
